// File: rtl/cipher_core_arbiter_if.sv
// Requester, response and core handshake bundle for the shared cipher core arbiter.
interface cipher_core_arbiter_if #(
  parameter int unsigned WIDTH = 128
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_block;
  logic             resp0_valid;
  logic             resp0_ready;
  logic [WIDTH-1:0] resp0_block;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_block;
  logic             resp1_valid;
  logic             resp1_ready;
  logic [WIDTH-1:0] resp1_block;
  logic             core_in_valid;
  logic             core_in_ready;
  logic [WIDTH-1:0] core_in_block;
  logic             core_out_valid;
  logic             core_out_ready;
  logic [WIDTH-1:0] core_out_block;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_block, resp0_ready,
    input  req1_valid, req1_block, resp1_ready,
    output req0_ready, resp0_valid, resp0_block,
    output req1_ready, resp1_valid, resp1_block,
    output core_in_valid, core_in_block, core_out_ready,
    input  core_in_ready, core_out_valid, core_out_block
  );

  // Requester/core side.
  modport master (
    output req0_valid, req0_block, resp0_ready,
    output req1_valid, req1_block, resp1_ready,
    input  req0_ready, resp0_valid, resp0_block,
    input  req1_ready, resp1_valid, resp1_block,
    input  core_in_valid, core_in_block, core_out_ready,
    output core_in_ready, core_out_valid, core_out_block
  );
endinterface

// File: rtl/cipher_core_arbiter.sv
// Round-robin arbiter sharing one block cipher core between two requesters,
// one transaction in flight, with a watchdog that aborts a stalled core.
module cipher_core_arbiter #(
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TW      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  cipher_core_arbiter_if.slave  bus,
  output logic                  busy,
  output logic                  grant,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic [TW-1:0]    wd;
  logic [WIDTH-1:0] blk;
  logic [WIDTH-1:0] res;
  logic             sel;
  logic             accept;
  logic             issue_xfer;
  logic             result_hit;
  logic             wd_expire;
  logic             resp_xfer;

  assign bus.core_in_block = blk;
  assign bus.resp0_block   = res;
  assign bus.resp1_block   = res;

  // Next-state decode plus the combinational ready signals.
  always_comb begin
    state_nxt          = state;
    accept             = 1'b0;
    issue_xfer         = 1'b0;
    result_hit         = 1'b0;
    wd_expire          = 1'b0;
    resp_xfer          = 1'b0;
    bus.req0_ready     = 1'b0;
    bus.req1_ready     = 1'b0;
    bus.core_out_ready = 1'b0;
    // Tie goes to the port that did not win last; otherwise the lone valid one.
    if (bus.req0_valid && bus.req1_valid) sel = ~last_grant;
    else                                  sel = bus.req1_valid;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          // A stray core result here is accepted and dropped.
          bus.core_out_ready = 1'b1;
          bus.req0_ready     = ~sel & bus.req0_valid;
          bus.req1_ready     = sel & bus.req1_valid;
          accept             = bus.req0_ready | bus.req1_ready;
          if (accept) state_nxt = S_ISSUE;
        end
        S_ISSUE: begin
          issue_xfer = bus.core_in_valid & bus.core_in_ready;
          if (issue_xfer) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          bus.core_out_ready = 1'b1;
          if (bus.core_out_valid) begin
            result_hit = 1'b1;
            state_nxt  = S_RESP;
          end else if (wd == TW'(TIMEOUT - 1)) begin
            wd_expire = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_RESP: begin
          resp_xfer = grant ? (bus.resp1_valid & bus.resp1_ready)
                            : (bus.resp0_valid & bus.resp0_ready);
          if (resp_xfer) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Datapath, watchdog and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk               <= '0;
      res               <= '0;
      wd                <= '0;
      grant             <= 1'b0;
      last_grant        <= 1'b1;
      busy              <= 1'b0;
      timeout_err       <= 1'b0;
      bus.core_in_valid <= 1'b0;
      bus.resp0_valid   <= 1'b0;
      bus.resp1_valid   <= 1'b0;
    end else begin
      busy              <= (state_nxt != S_IDLE);
      timeout_err       <= wd_expire;
      bus.core_in_valid <= (state_nxt == S_ISSUE);
      bus.resp0_valid   <= (state_nxt == S_RESP) & ~grant;
      bus.resp1_valid   <= (state_nxt == S_RESP) & grant;
      if (accept) begin
        blk   <= sel ? bus.req1_block : bus.req0_block;
        grant <= sel;
      end
      if (issue_xfer) wd <= '0;
      else if ((state == S_WAIT) && !result_hit && !wd_expire) wd <= wd + TW'(1);
      if (result_hit) res <= bus.core_out_block;
      if (wd_expire || resp_xfer) last_grant <= grant;
    end
  end

endmodule

// File: tb/tb_cipher_core_arbiter.sv
// Directed bench for cipher_core_arbiter: requester and core drivers, a
// transaction-level reference model checked every cycle, and literal checks.
module tb_cipher_core_arbiter;
  localparam int unsigned W  = 128;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic grant;
  logic timeout_err;

  cipher_core_arbiter_if #(.WIDTH(W)) bus ();

  cipher_core_arbiter #(.WIDTH(W), .TIMEOUT(TO), .TW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy(busy), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  function automatic void chk1(input string nm, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endfunction

  function automatic void chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void chki(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Requester queues, core behaviour knobs and DUT response logs.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] r0_log[$];
  logic [W-1:0] r1_log[$];
  logic         glog[$];
  int           core_lat  = 0;
  bit           core_mute = 1'b0;
  int           to_cnt    = 0;
  int           cyc       = 0;
  int           cin_cyc   = 0;
  int           to_cyc    = 0;

  // Reference model state: one transaction at a time.
  bit           m_active;
  bit           m_issued;
  bit           m_got;
  logic         m_port;
  logic         m_last;
  logic [W-1:0] m_blk;
  logic [W-1:0] m_res;
  int           m_wcnt;
  bit           exp_to;

  // Requesters: present queue head, hold until the transfer, then advance.
  initial begin
    bit x0, x1;
    bus.req0_valid = 1'b0; bus.req0_block = '0;
    bus.req1_valid = 1'b0; bus.req1_block = '0;
    forever begin
      @(negedge clk);
      x0 = bus.req0_valid && bus.req0_ready;
      x1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk); #1;
      if (x0 && q0.size() > 0) void'(q0.pop_front());
      if (x1 && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0) begin bus.req0_valid = 1'b1; bus.req0_block = q0[0]; end
      else begin bus.req0_valid = 1'b0; bus.req0_block = '0; end
      if (q1.size() > 0) begin bus.req1_valid = 1'b1; bus.req1_block = q1[0]; end
      else begin bus.req1_valid = 1'b0; bus.req1_block = '0; end
    end
  end

  // Core: returns the inverted block, raising valid in WAIT cycle core_lat+1.
  initial begin
    bit ix, ox;
    logic [W-1:0] ib, pend;
    int cnt;
    cnt = -1; pend = '0;
    bus.core_out_valid = 1'b0; bus.core_out_block = '0;
    forever begin
      @(negedge clk);
      ix = bus.core_in_valid && bus.core_in_ready;
      ib = bus.core_in_block;
      ox = bus.core_out_valid && bus.core_out_ready;
      @(posedge clk); #1;
      if (rst) begin
        cnt = -1;
        bus.core_out_valid = 1'b0;
      end else begin
        if (ox) bus.core_out_valid = 1'b0;
        if (ix && !core_mute) begin pend = ~ib; cnt = core_lat; end
        if (cnt == 0) begin
          bus.core_out_valid = 1'b1; bus.core_out_block = pend; cnt = -1;
        end else if (cnt > 0) cnt--;
      end
    end
  end

  // Compare process: checks every cycle against the transaction model.
  initial begin
    bit v0, v1;
    logic msel;
    m_active = 0; m_issued = 0; m_got = 0; m_port = 0; m_last = 1'b1;
    m_blk = '0; m_res = '0; m_wcnt = 0; exp_to = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk1("rst_req0_ready",  bus.req0_ready,     1'b0);
        chk1("rst_req1_ready",  bus.req1_ready,     1'b0);
        chk1("rst_resp0_valid", bus.resp0_valid,    1'b0);
        chk1("rst_resp1_valid", bus.resp1_valid,    1'b0);
        chk1("rst_core_in_v",   bus.core_in_valid,  1'b0);
        chk1("rst_core_out_r",  bus.core_out_ready, 1'b0);
        chk1("rst_busy",        busy,               1'b0);
        chk1("rst_grant",       grant,              1'b0);
        chk1("rst_timeout_err", timeout_err,        1'b0);
        m_active = 0; m_last = 1'b1; exp_to = 0;
      end else begin
        chk1("timeout_err", timeout_err, exp_to);
        exp_to = 0;
        if (timeout_err) begin to_cnt++; to_cyc = cyc; end
        if (bus.resp0_valid && bus.resp0_ready) begin r0_log.push_back(bus.resp0_block); glog.push_back(grant); end
        if (bus.resp1_valid && bus.resp1_ready) begin r1_log.push_back(bus.resp1_block); glog.push_back(grant); end
        v0 = bus.req0_valid; v1 = bus.req1_valid;
        if (!m_active) begin
          chk1("idle_busy",       busy,               1'b0);
          chk1("idle_core_in_v",  bus.core_in_valid,  1'b0);
          chk1("idle_core_out_r", bus.core_out_ready, 1'b1);
          chk1("idle_resp0_v",    bus.resp0_valid,    1'b0);
          chk1("idle_resp1_v",    bus.resp1_valid,    1'b0);
          if (v0 || v1) begin
            msel = (v0 && v1) ? ~m_last : (v1 ? 1'b1 : 1'b0);
            chk1("idle_req0_ready", bus.req0_ready, ~msel);
            chk1("idle_req1_ready", bus.req1_ready, msel);
            m_active = 1; m_issued = 0; m_got = 0; m_port = msel;
            m_blk = msel ? bus.req1_block : bus.req0_block;
          end else begin
            chk1("idle_req0_ready", bus.req0_ready, 1'b0);
            chk1("idle_req1_ready", bus.req1_ready, 1'b0);
          end
        end else begin
          chk1("act_busy",       busy,           1'b1);
          chk1("act_grant",      grant,          m_port);
          chk1("act_req0_ready", bus.req0_ready, 1'b0);
          chk1("act_req1_ready", bus.req1_ready, 1'b0);
          if (!m_issued) begin
            chk1("iss_core_in_v",   bus.core_in_valid,  1'b1);
            chkw("iss_core_in_blk", bus.core_in_block,  m_blk);
            chk1("iss_core_out_r",  bus.core_out_ready, 1'b0);
            chk1("iss_resp_v",      bus.resp0_valid | bus.resp1_valid, 1'b0);
            if (bus.core_in_ready) begin m_issued = 1; m_wcnt = 0; cin_cyc = cyc; end
          end else if (!m_got) begin
            chk1("wait_core_in_v",  bus.core_in_valid,  1'b0);
            chk1("wait_core_out_r", bus.core_out_ready, 1'b1);
            chk1("wait_resp_v",     bus.resp0_valid | bus.resp1_valid, 1'b0);
            if (bus.core_out_valid) begin
              m_got = 1; m_res = bus.core_out_block;
            end else begin
              m_wcnt++;
              if (m_wcnt == int'(TO)) begin m_active = 0; m_last = m_port; exp_to = 1; end
            end
          end else begin
            chk1("resp0_valid", bus.resp0_valid, ~m_port);
            chk1("resp1_valid", bus.resp1_valid, m_port);
            chkw("resp_block", m_port ? bus.resp1_block : bus.resp0_block, m_res);
            if (m_port ? bus.resp1_ready : bus.resp0_ready) begin m_active = 0; m_last = m_port; end
          end
        end
      end
    end
  end

  task automatic wait_idle(input int max, input string nm);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && !m_active && !bus.req0_valid && !bus.req1_valid)
           && n < max) begin
      @(negedge clk); n++;
    end
    nvec++;
    if (n >= max) begin nerr++; $display("FAIL %s: still busy after %0d cycles", nm, n); end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic clear_logs();
    r0_log.delete(); r1_log.delete(); glog.delete();
  endtask

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "time limit");
  end

  // Directed scenarios.
  initial begin
    logic [W-1:0] a0, a1, b0, b1, x, y, t, u, r, r2, e;
    logic         exp_g [4];
    int           n, pre;
    a0 = 128'h00112233445566778899AABBCCDDEEFF;
    a1 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    b0 = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
    b1 = 128'h13579BDF2468ACE0FEDCBA9876543210;
    x  = 128'hA5A5A5A55A5A5A5A0123456789ABCDEF;
    y  = 128'h5555AAAA5555AAAA3333CCCC3333CCCC;
    t  = 128'h11111111222222223333333344444444;
    u  = 128'h99998888777766665555444433332222;
    r  = 128'hFEDCBA98765432100123456789ABCDEF;
    r2 = 128'h0000000000000000FFFFFFFFFFFFFFFF;
    e  = 128'h7777777777777777EEEEEEEEEEEEEEEE;
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b0;
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1; bus.core_in_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;

    // Single request, core answers in the third WAIT cycle.
    core_lat = 2; clear_logs();
    q0.push_back(a0);
    wait_idle(60, "single_done");
    chki("single_resp0_count", r0_log.size(), 1);
    if (r0_log.size() > 0) chkw("single_resp0_block", r0_log[0], 128'hFFEEDDCCBBAA99887766554433221100);
    chki("single_resp1_count", r1_log.size(), 0);
    chk1("single_grant", grant, 1'b0);
    chk1("single_busy", busy, 1'b0);

    // Tie from reset: strict alternation, responses back to the issuer.
    do_reset();
    core_lat = 0; clear_logs();
    q0.push_back(a0); q0.push_back(a1);
    q1.push_back(b0); q1.push_back(b1);
    wait_idle(100, "rr_done");
    chki("rr_grant_count", glog.size(), 4);
    for (int i = 0; i < 4; i++) if (i < glog.size()) chk1("rr_grant_order", glog[i], exp_g[i]);
    chki("rr_resp0_count", r0_log.size(), 2);
    chki("rr_resp1_count", r1_log.size(), 2);
    if (r0_log.size() == 2) begin chkw("rr_resp0_a0", r0_log[0], ~a0); chkw("rr_resp0_a1", r0_log[1], ~a1); end
    if (r1_log.size() == 2) begin chkw("rr_resp1_b0", r1_log[0], ~b0); chkw("rr_resp1_b1", r1_log[1], ~b1); end

    // Backpressure on the core input and on the response side.
    core_lat = 1; clear_logs();
    bus.core_in_ready = 1'b0; bus.resp0_ready = 1'b0;
    q0.push_back(x); q1.push_back(y);
    n = 0;
    while (!bus.core_in_valid && n < 20) begin @(negedge clk); n++; end
    chk1("bp_core_in_seen", bus.core_in_valid, 1'b1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 bus.core_in_ready = 1'b1;
    n = 0;
    while (!bus.resp0_valid && n < 20) begin @(negedge clk); n++; end
    chk1("bp_resp0_seen", bus.resp0_valid, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 bus.resp0_ready = 1'b1;
    wait_idle(60, "bp_done");
    chki("bp_resp0_count", r0_log.size(), 1);
    chki("bp_resp1_count", r1_log.size(), 1);
    if (r0_log.size() == 1) chkw("bp_resp0_block", r0_log[0], ~x);
    if (r1_log.size() == 1) chkw("bp_resp1_block", r1_log[0], ~y);

    // Watchdog: silent core, then requester 1 is served.
    core_mute = 1'b1; clear_logs(); pre = to_cnt;
    q0.push_back(t);
    n = 0;
    while (to_cnt == pre && n < 40) begin @(negedge clk); n++; end
    chki("to_pulse_seen", to_cnt - pre, 1);
    // Seen on the negedge after the 8th rising edge following the core_in transfer edge.
    chki("to_delay", to_cyc - cin_cyc, 9);
    core_mute = 1'b0;
    q1.push_back(u);
    wait_idle(60, "to_next_done");
    chki("to_pulse_width", to_cnt - pre, 1);
    chki("to_resp0_count", r0_log.size(), 0);
    chki("to_resp1_count", r1_log.size(), 1);
    if (r1_log.size() == 1) chkw("to_resp1_block", r1_log[0], ~u);

    // Asynchronous reset while waiting on the core.
    core_mute = 1'b1; clear_logs();
    q0.push_back(r);
    n = 0;
    while (!(m_active && m_issued) && n < 20) begin @(negedge clk); n++; end
    chki("rw_in_wait", int'(m_active && m_issued), 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk1("rw_async_req0_ready",  bus.req0_ready,     1'b0);
    chk1("rw_async_req1_ready",  bus.req1_ready,     1'b0);
    chk1("rw_async_core_in_v",   bus.core_in_valid,  1'b0);
    chk1("rw_async_core_out_r",  bus.core_out_ready, 1'b0);
    chk1("rw_async_resp_v",      bus.resp0_valid | bus.resp1_valid, 1'b0);
    chk1("rw_async_busy",        busy,               1'b0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    core_mute = 1'b0; core_lat = 1;
    q0.push_back(r2);
    wait_idle(60, "rw_after_done");
    chki("rw_resp0_count", r0_log.size(), 1);
    if (r0_log.size() == 1) chkw("rw_resp0_block", r0_log[0], ~r2);
    chki("rw_resp1_count", r1_log.size(), 0);

    // Result arrives in the 8th WAIT cycle: response wins over the watchdog.
    core_lat = 7; clear_logs(); pre = to_cnt;
    q0.push_back(e);
    wait_idle(60, "edge_done");
    chki("edge_no_timeout", to_cnt - pre, 0);
    chki("edge_resp0_count", r0_log.size(), 1);
    if (r0_log.size() == 1) chkw("edge_resp0_block", r0_log[0], ~e);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
